// File: rtl/id_queue_drain.sv
// rtl/id_queue_drain.sv - response-side reader for an id_queue output port
// Optional saturating orphan counter: ID_QUEUE_DRAIN_ERR_CNT_EN.
module id_queue_drain #(
    parameter int  ID_WIDTH      = 1,
    parameter type data_t        = logic,
    parameter int  ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ID_WIDTH-1:0]      rsp_id_i,
    input  logic                     rsp_last_i,
    input  logic                     rsp_valid_i,
    output logic                     rsp_ready_o,
    output logic [ID_WIDTH-1:0]      q_id_o,
    output logic                     q_pop_o,
    output logic                     q_req_o,
    input  logic                     q_gnt_i,
    input  logic [$bits(data_t)-1:0] q_data_i,
    input  logic                     q_data_valid_i,
    output logic [$bits(data_t)-1:0] out_data_o,
    output logic [ID_WIDTH-1:0]      out_id_o,
    output logic                     out_last_o,
    output logic                     out_orphan_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        OUTPUT
    } state_t;

    state_t                     state_q;
    logic [ID_WIDTH-1:0]        hold_id_q;
    logic                       hold_last_q;
    logic [$bits(data_t)-1:0]   out_data_q;
    logic [ID_WIDTH-1:0]        out_id_q;
    logic                       out_last_q;
    logic                       out_orphan_q;
    logic                       err_q;
    logic                       grant_orphan;

    assign grant_orphan = (state_q == LOOKUP) && q_gnt_i && !q_data_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            hold_id_q    <= '0;
            hold_last_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            out_orphan_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rsp_valid_i) begin
                        hold_id_q   <= rsp_id_i;
                        hold_last_q <= rsp_last_i;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Queue push port has priority; wait for the grant with the request held.
                    if (q_gnt_i) begin
                        out_data_q   <= q_data_valid_i ? q_data_i : '0;
                        out_id_q     <= hold_id_q;
                        out_last_q   <= hold_last_q;
                        out_orphan_q <= !q_data_valid_i;
                        if (!q_data_valid_i) begin
                            err_q <= 1'b1;
                        end
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready_i) begin
                        if (rsp_valid_i) begin
                            hold_id_q   <= rsp_id_i;
                            hold_last_q <= rsp_last_i;
                            state_q     <= LOOKUP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ID_QUEUE_DRAIN_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (grant_orphan && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_orphan;
    assign unused_orphan = grant_orphan;
    assign err_cnt_o     = '0;
`endif

    // The next beat is taken in the same edge that the output beat leaves.
    assign rsp_ready_o  = (state_q == IDLE) || ((state_q == OUTPUT) && out_ready_i);
    assign q_req_o      = (state_q == LOOKUP);
    assign q_pop_o      = (state_q == LOOKUP) && hold_last_q;
    assign q_id_o       = hold_id_q;
    assign out_valid_o  = (state_q == OUTPUT);
    assign out_data_o   = out_data_q;
    assign out_id_o     = out_id_q;
    assign out_last_o   = out_last_q;
    assign out_orphan_o = out_orphan_q;
    assign err_o        = err_q;

endmodule
